// File: rtl/nmcu_mem_arbiter_if.sv
// Bus bundle for the NMCU memory arbiter: NUM_CH upstream request/response
// channels plus the single downstream memory port.
interface nmcu_mem_arbiter_if #(
   parameter int NUM_CH     = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
);
   logic [NUM_CH-1:0]                 m_req_valid;
   logic [NUM_CH-1:0]                 m_req_write_en;
   logic [NUM_CH-1:0][ADDR_WIDTH-1:0] m_req_addr;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] m_req_wdata;
   logic [NUM_CH-1:0][LEN_WIDTH-1:0]  m_req_len;
   logic [NUM_CH-1:0]                 m_req_ready;
   logic [NUM_CH-1:0]                 m_resp_valid;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0] m_resp_rdata;

   logic                  s_req_valid;
   logic                  s_req_write_en;
   logic [ADDR_WIDTH-1:0] s_req_addr;
   logic [DATA_WIDTH-1:0] s_req_wdata;
   logic [LEN_WIDTH-1:0]  s_req_len;
   logic                  s_req_ready;
   logic                  s_resp_valid;
   logic [DATA_WIDTH-1:0] s_resp_rdata;

   // Requesters and memory model side
   modport master (
      output m_req_valid, m_req_write_en, m_req_addr, m_req_wdata, m_req_len,
      input  m_req_ready, m_resp_valid, m_resp_rdata,
      input  s_req_valid, s_req_write_en, s_req_addr, s_req_wdata, s_req_len,
      output s_req_ready, s_resp_valid, s_resp_rdata
   );

   // Arbiter side
   modport slave (
      input  m_req_valid, m_req_write_en, m_req_addr, m_req_wdata, m_req_len,
      output m_req_ready, m_resp_valid, m_resp_rdata,
      output s_req_valid, s_req_write_en, s_req_addr, s_req_wdata, s_req_len,
      input  s_req_ready, s_resp_valid, s_resp_rdata
   );
endinterface

// File: rtl/nmcu_mem_arbiter.sv
// Round-robin N-channel memory arbiter with write-burst locking. Read
// responses are steered back to their issuer through an in-order tag FIFO.
module nmcu_mem_arbiter #(
   parameter int NUM_CH          = 4,
   parameter int MAX_OUTSTANDING = 8,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int LEN_WIDTH       = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   nmcu_mem_arbiter_if.slave                bus,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
   output logic                             err_o
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, LOCK} state_t;

   state_t               state_q, state_d;
   logic [CH_W-1:0]      rr_q, rr_d;
   logic [CH_W-1:0]      lock_ch_q, lock_ch_d;
   logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [CH_W-1:0]      fifo_ch_q [MAX_OUTSTANDING];
   logic [CH_W-1:0]      fifo_ch_d [MAX_OUTSTANDING];
   logic [LEN_WIDTH-1:0] fifo_beats_q [MAX_OUTSTANDING];
   logic [LEN_WIDTH-1:0] fifo_beats_d [MAX_OUTSTANDING];
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 err_q, err_d;

   logic                 win_found;
   logic [CH_W-1:0]      win_ch;
   logic                 gnt_any, gate, xfer, push, pop;
   logic [CH_W-1:0]      gnt_ch;
   logic [LEN_WIDTH-1:0] n_beats;
   logic                 fifo_full, fifo_empty;

   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
      return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
   endfunction

   assign fifo_full     = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty    = (count_q == '0);
   assign outstanding_o = count_q;
   assign err_o         = err_q;

   // Pick the first valid channel at or above the round-robin pointer, wrapping
   always_comb begin
      logic [CH_W:0] scan;
      win_found = 1'b0;
      win_ch    = '0;
      scan      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         scan = {1'b0, rr_q} + (CH_W+1)'(i);
         if (scan >= (CH_W+1)'(NUM_CH)) scan = scan - (CH_W+1)'(NUM_CH);
         if (!win_found && bus.m_req_valid[scan[CH_W-1:0]]) begin
            win_found = 1'b1;
            win_ch    = scan[CH_W-1:0];
         end
      end
   end

   // Grant, forward path, burst FSM, response routing and tag FIFO bookkeeping
   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      lock_ch_d    = lock_ch_q;
      beat_cnt_d   = beat_cnt_q;
      fifo_ch_d    = fifo_ch_q;
      fifo_beats_d = fifo_beats_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      err_d        = err_q;
      push         = 1'b0;
      pop          = 1'b0;

      if (state_q == LOCK) begin
         gnt_any = 1'b1;
         gnt_ch  = lock_ch_q;
         gate    = 1'b1;
      end else begin
         gnt_any = win_found;
         gnt_ch  = win_ch;
         gate    = bus.m_req_write_en[win_ch] || !fifo_full;
      end
      if (rst) gnt_any = 1'b0;

      bus.m_req_ready    = '0;
      bus.s_req_valid    = 1'b0;
      bus.s_req_write_en = 1'b0;
      bus.s_req_addr     = '0;
      bus.s_req_wdata    = '0;
      bus.s_req_len      = '0;
      if (gnt_any) begin
         bus.m_req_ready[gnt_ch] = bus.s_req_ready && gate;
         bus.s_req_valid         = bus.m_req_valid[gnt_ch] && gate;
         bus.s_req_write_en      = (state_q == LOCK) || bus.m_req_write_en[gnt_ch];
         bus.s_req_addr          = bus.m_req_addr[gnt_ch];
         bus.s_req_wdata         = bus.m_req_wdata[gnt_ch];
         bus.s_req_len           = bus.m_req_len[gnt_ch];
      end
      xfer    = gnt_any && bus.m_req_valid[gnt_ch] && bus.s_req_ready && gate;
      n_beats = (bus.m_req_len[gnt_ch] == '0) ? LEN_WIDTH'(1) : bus.m_req_len[gnt_ch];

      case (state_q)
         IDLE: begin
            if (xfer) begin
               if (!bus.m_req_write_en[gnt_ch]) begin
                  push = 1'b1;
                  rr_d = next_ch(gnt_ch);
               end else if (n_beats == LEN_WIDTH'(1)) begin
                  rr_d = next_ch(gnt_ch);
               end else begin
                  lock_ch_d  = gnt_ch;
                  beat_cnt_d = n_beats - 1'b1;
                  state_d    = LOCK;
               end
            end
         end
         LOCK: begin
            if (xfer) begin
               beat_cnt_d = beat_cnt_q - 1'b1;
               if (beat_cnt_q == LEN_WIDTH'(1)) begin
                  state_d = IDLE;
                  rr_d    = next_ch(lock_ch_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      bus.m_resp_valid = '0;
      bus.m_resp_rdata = '0;
      if (bus.s_resp_valid && !rst) begin
         if (!fifo_empty) begin
            bus.m_resp_valid[fifo_ch_q[rd_ptr_q]] = 1'b1;
            bus.m_resp_rdata[fifo_ch_q[rd_ptr_q]] = bus.s_resp_rdata;
            if (fifo_beats_q[rd_ptr_q] == LEN_WIDTH'(1)) pop = 1'b1;
            else fifo_beats_d[rd_ptr_q] = fifo_beats_q[rd_ptr_q] - 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end

      if (push) begin
         fifo_ch_d[wr_ptr_q]    = gnt_ch;
         fifo_beats_d[wr_ptr_q] = n_beats;
         wr_ptr_d               = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // State register; reset abandons any burst and flushes the tag FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         lock_ch_q  <= '0;
         beat_cnt_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_ch_q[i]    <= '0;
            fifo_beats_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         lock_ch_q    <= lock_ch_d;
         beat_cnt_q   <= beat_cnt_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         err_q        <= err_d;
         fifo_ch_q    <= fifo_ch_d;
         fifo_beats_q <= fifo_beats_d;
      end
   end
endmodule

// File: tb/tb_nmcu_mem_arbiter.sv
// Self-checking bench for nmcu_mem_arbiter: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_nmcu_mem_arbiter;
   localparam int NUM_CH  = 4;
   localparam int MAX_OUT = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] outstanding;
   logic       err;

   int checks = 0;
   int errors = 0;

   nmcu_mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

   nmcu_mem_arbiter #(.NUM_CH(NUM_CH), .MAX_OUTSTANDING(MAX_OUT), .ADDR_WIDTH(32),
                      .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .bus(bus), .outstanding_o(outstanding), .err_o(err));

   always #5 clk = ~clk;

   // Requester state: current request held until its beats are accepted
   bit          cv [NUM_CH];
   bit          cwe [NUM_CH];
   logic [31:0] caddr [NUM_CH];
   logic [31:0] cwdata [NUM_CH];
   logic [7:0]  clen [NUM_CH];
   int          cleft [NUM_CH];
   int          cpause [NUM_CH];

   // Reference model: arbitration pointer, burst lock, outstanding reads
   int          m_rr = 0;
   bit          m_locked = 0;
   int          m_lock_ch = 0;
   int          m_lock_left = 0;
   int          txn_ch [$];
   int          txn_left [$];
   bit          err_exp = 0;
   int          mem_ch [$];
   logic [31:0] mem_data [$];
   int          xfer_log [$];

   // Bench controls
   bit rst_next = 1'b1;
   bit reg_check_en = 1'b0;
   bit force_spur = 1'b0;
   bit auto_mode = 1'b0;
   int resp_mode = 0;
   int sready_mode = 1;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic post(input int ch, input bit we, input logic [31:0] addr, input int len);
      cv[ch]    = 1'b1;
      cwe[ch]   = we;
      caddr[ch] = addr;
      clen[ch]  = 8'(len);
      cleft[ch] = we ? ((len == 0) ? 1 : len) : 1;
   endtask

   task automatic applyStimulus();
      logic [NUM_CH-1:0] exp_ready, exp_rv;
      int   g, c, n;
      bit   any, gate, xfer, resp_on, resp_has;
      @(negedge clk);
      if (reg_check_en) begin
         checkOutput("outstanding", outstanding, txn_ch.size());
         checkOutput("err", err, err_exp);
      end
      rst = rst_next;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         cwdata[ch]                = $urandom;
         bus.m_req_valid[ch]       = cv[ch] && (cpause[ch] == 0);
         bus.m_req_write_en[ch]    = cwe[ch];
         bus.m_req_addr[ch]        = caddr[ch];
         bus.m_req_wdata[ch]       = cwdata[ch];
         bus.m_req_len[ch]         = clen[ch];
      end
      bus.s_req_ready = (sready_mode == 1) ? 1'b1 : (($urandom % 4) != 0);
      resp_on  = 1'b0;
      resp_has = 1'b0;
      if (force_spur) resp_on = 1'b1;
      else if (mem_ch.size() > 0 && (resp_mode == 1 || (resp_mode == 2 && ($urandom % 2) == 1))) begin
         resp_on  = 1'b1;
         resp_has = 1'b1;
      end
      bus.s_resp_valid = resp_on;
      bus.s_resp_rdata = resp_has ? mem_data[0] : $urandom;
      #1;

      any = 1'b0; g = 0; gate = 1'b0;
      if (!rst) begin
         if (m_locked) begin
            any = 1'b1; g = m_lock_ch; gate = 1'b1;
         end else begin
            for (int i = 0; i < NUM_CH; i++) begin
               c = (m_rr + i) % NUM_CH;
               if (!any && bus.m_req_valid[c]) begin any = 1'b1; g = c; end
            end
            gate = cwe[g] || (txn_ch.size() < MAX_OUT);
         end
      end
      exp_ready = '0;
      if (any) exp_ready[g] = bus.s_req_ready && gate;
      xfer = any && bus.m_req_valid[g] && exp_ready[g];
      checkOutput("m_req_ready", bus.m_req_ready, exp_ready);
      checkOutput("s_req_valid", bus.s_req_valid, any && bus.m_req_valid[g] && gate);
      if (rst) checkOutput("s_req_addr_rst", bus.s_req_addr, 0);
      if (xfer) begin
         checkOutput("s_req_addr", bus.s_req_addr, caddr[g]);
         checkOutput("s_req_wdata", bus.s_req_wdata, cwdata[g]);
         checkOutput("s_req_write_en", bus.s_req_write_en, m_locked ? 1'b1 : cwe[g]);
         if (!m_locked) checkOutput("s_req_len", bus.s_req_len, clen[g]);
      end
      exp_rv = '0;
      if (!rst && resp_on && txn_ch.size() > 0) exp_rv[txn_ch[0]] = 1'b1;
      checkOutput("m_resp_valid", bus.m_resp_valid, exp_rv);
      if (exp_rv != '0) checkOutput("m_resp_rdata", bus.m_resp_rdata[txn_ch[0]], bus.s_resp_rdata);

      if (rst) begin
         txn_ch.delete(); txn_left.delete(); mem_ch.delete(); mem_data.delete();
         m_rr = 0; m_locked = 1'b0; err_exp = 1'b0;
         for (int ch = 0; ch < NUM_CH; ch++)
            if (cv[ch] && cwe[ch]) cleft[ch] = (clen[ch] == 0) ? 1 : int'(clen[ch]);
      end else begin
         if (resp_on) begin
            if (txn_ch.size() > 0) begin
               txn_left[0]--;
               if (txn_left[0] == 0) begin void'(txn_ch.pop_front()); void'(txn_left.pop_front()); end
            end else err_exp = 1'b1;
            if (resp_has) begin void'(mem_ch.pop_front()); void'(mem_data.pop_front()); end
         end
         if (xfer) begin
            xfer_log.push_back(g);
            n = (clen[g] == 0) ? 1 : int'(clen[g]);
            if (m_locked) begin
               m_lock_left--;
               if (m_lock_left == 0) begin m_locked = 1'b0; m_rr = (g + 1) % NUM_CH; end
            end else if (!cwe[g]) begin
               txn_ch.push_back(g); txn_left.push_back(n);
               for (int b = 0; b < n; b++) begin mem_ch.push_back(g); mem_data.push_back($urandom); end
               m_rr = (g + 1) % NUM_CH;
            end else if (n == 1) begin
               m_rr = (g + 1) % NUM_CH;
            end else begin
               m_locked = 1'b1; m_lock_ch = g; m_lock_left = n - 1;
            end
            cleft[g]--;
            if (cleft[g] == 0) cv[g] = 1'b0;
         end
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (cpause[ch] > 0) cpause[ch]--;
         if (auto_mode && !cv[ch] && ($urandom % 3) == 0)
            post(ch, ($urandom % 5) == 0, $urandom & 32'hFFFF_FFFC, $urandom % 4);
      end
   endtask

   task automatic run(input int cycles);
      repeat (cycles) applyStimulus();
   endtask

   task automatic drain(input int budget);
      bit busy;
      int used = 0;
      busy = 1'b1;
      while (busy && used < budget) begin
         busy = (mem_ch.size() > 0);
         for (int ch = 0; ch < NUM_CH; ch++) if (cv[ch]) busy = 1'b1;
         if (busy) begin applyStimulus(); used++; end
      end
      checks++;
      assert (!busy) else begin
         errors++;
         $error("FAIL drain_timeout observed=busy expected=idle within %0d cycles", budget);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         cv[ch] = 0; cwe[ch] = 0; caddr[ch] = '0; clen[ch] = '0; cleft[ch] = 0; cpause[ch] = 0;
      end
      bus.s_resp_valid = 1'b0;
      $display("[TB] reset");
      rst_next = 1'b1;
      run(2);
      reg_check_en = 1'b1;
      rst_next = 1'b0;
      run(1);

      $display("[TB] four single-beat reads, round-robin order");
      resp_mode = 0;
      for (int ch = 0; ch < NUM_CH; ch++) post(ch, 1'b0, 32'h10 * (ch + 1), 1);
      xfer_log.delete();
      run(5);
      checkOutput("grant_count", xfer_log.size(), 4);
      for (int i = 0; i < 4; i++) checkOutput("grant_order", xfer_log[i], i);
      @(posedge clk); #1;
      checkOutput("outstanding_four", outstanding, 4);
      resp_mode = 1;
      drain(50);

      $display("[TB] write burst lock with stall");
      xfer_log.delete();
      post(1, 1'b1, 32'h100, 4);
      post(2, 1'b0, 32'h180, 1);
      run(2);
      cpause[1] = 2;
      run(2);
      checkOutput("lock_stall", xfer_log.size(), 2);
      run(3);
      checkOutput("burst_count", xfer_log.size(), 5);
      for (int i = 0; i < 4; i++) checkOutput("burst_owner", xfer_log[i], 1);
      checkOutput("after_burst", xfer_log[4], 2);
      drain(50);

      $display("[TB] multi-beat read routing");
      resp_mode = 0;
      post(0, 1'b0, 32'h200, 3);
      run(1);
      post(3, 1'b0, 32'h300, 2);
      run(2);
      @(posedge clk); #1;
      checkOutput("outstanding_two", outstanding, 2);
      resp_mode = 1;
      run(3);
      @(posedge clk); #1;
      checkOutput("outstanding_one", outstanding, 1);
      run(2);
      @(posedge clk); #1;
      checkOutput("outstanding_zero", outstanding, 0);

      $display("[TB] tag FIFO full");
      resp_mode = 0;
      for (int r = 0; r < 2; r++) begin
         for (int ch = 0; ch < NUM_CH; ch++) post(ch, 1'b0, 32'h500 + 32'h10 * (r * 4 + ch), 1);
         run(4);
      end
      post(0, 1'b0, 32'h900, 1);
      run(1);
      checkOutput("full_block", bus.m_req_ready[0], 0);
      run(1);
      checkOutput("full_block_hold", bus.m_req_ready[0], 0);
      xfer_log.delete();
      resp_mode = 1;
      run(1);
      checkOutput("full_pop_cycle", bus.m_req_ready[0], 0);
      resp_mode = 0;
      run(1);
      checkOutput("accept_after_pop", bus.m_req_ready[0], 1);
      checkOutput("accept_log", xfer_log.size(), 1);
      resp_mode = 1;
      drain(60);

      $display("[TB] spurious response");
      force_spur = 1'b1;
      run(1);
      force_spur = 1'b0;
      run(2);
      @(posedge clk); #1;
      checkOutput("err_sticky", err, 1);
      rst_next = 1'b1;
      run(1);
      rst_next = 1'b0;
      run(1);
      checkOutput("err_cleared", err, 0);

      $display("[TB] reset during lock with reads outstanding");
      resp_mode = 0;
      post(0, 1'b0, 32'hA00, 1);
      post(2, 1'b0, 32'hA20, 1);
      post(3, 1'b0, 32'hA30, 1);
      run(3);
      post(1, 1'b1, 32'h400, 4);
      run(1);
      post(0, 1'b0, 32'hB00, 1);
      rst_next = 1'b1;
      run(2);
      @(posedge clk); #1;
      checkOutput("rst_flush", outstanding, 0);
      rst_next = 1'b0;
      force_spur = 1'b1;
      run(1);
      force_spur = 1'b0;
      run(1);
      checkOutput("late_resp_err", err, 1);
      rst_next = 1'b1;
      run(1);
      rst_next = 1'b0;
      resp_mode = 1;
      drain(60);

      $display("[TB] randomized traffic");
      auto_mode = 1'b1;
      sready_mode = 2;
      resp_mode = 2;
      run(3000);
      auto_mode = 1'b0;
      sready_mode = 1;
      resp_mode = 1;
      drain(500);
      run(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
